// File: rtl/rr_lock_arbiter_if.sv
// Request/grant bundle between the requesters and the round-robin lock arbiter.
// The master side drives the requests and the done strobe. The slave side is the
// arbiter, and it returns the registered grant information.
interface rr_lock_arbiter_if;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       busy;
    logic       timeout;

    modport master (
        output req,
        output done,
        input  grant,
        input  grant_id,
        input  busy,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output grant,
        output grant_id,
        output busy,
        output timeout
    );
endinterface

// File: rtl/rr_lock_arbiter.sv
// Four-way round-robin arbiter for one shared resource.
// A grant is held until done arrives, the owner drops its request, or HOLD_MAX
// cycles have passed. After every release the arbiter spends one cycle in RELEASE
// with no grant. The priority pointer then moves to the requester just after the
// one that was released.
module rr_lock_arbiter #(
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic               clk,
    input  logic               reset,
    rr_lock_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [7:0] hold_q, hold_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] id_q, id_d;
    logic       busy_q, busy_d;
    logic       timeout_q, timeout_d;

    logic [1:0] pick;
    logic [1:0] idx;
    logic       hold_limit;
    logic       owner_req;

    assign hold_limit = (hold_q == 8'(HOLD_MAX));
    assign owner_req  = bus.req[id_q];

    // Pick the first requester at or after ptr, wrapping around the four slots.
    always_comb begin
        pick = 2'd0;
        idx  = 2'd0;
        // Scan the slots from the farthest one to the nearest, so the nearest set bit is written last and wins.
        for (int k = 3; k >= 0; k--) begin
            idx = ptr_q + 2'(k);
            if (bus.req[idx]) begin
                pick = idx;
            end
        end
    end

    // Next-state and next-output logic for the IDLE/GRANT/RELEASE controller.
    always_comb begin
        // NOTE: every signal is given a default before the case statement.
        // A path that leaves a signal unassigned would otherwise infer a latch.
        state_d   = state_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        grant_d   = grant_q;
        id_d      = id_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE, RELEASE: begin
                if (|bus.req) begin
                    state_d = GRANT;
                    grant_d = 4'b0001 << pick;
                    id_d    = pick;
                    busy_d  = 1'b1;
                    hold_d  = 8'd1;
                end else begin
                    state_d = IDLE;
                    grant_d = 4'b0000;
                    busy_d  = 1'b0;
                end
            end
            GRANT: begin
                if (bus.done || !owner_req || hold_limit) begin
                    state_d   = RELEASE;
                    grant_d   = 4'b0000;
                    busy_d    = 1'b0;
                    ptr_d     = id_q + 2'd1;
                    // Flag a timeout only when the hold limit is the sole reason for the release.
                    timeout_d = hold_limit && !bus.done && owner_req;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 4'b0000;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs, with a synchronous reset that overrides everything else.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments.
        // Every register then samples the values from before the clock edge.
        if (reset) begin
            state_q   <= IDLE;
            ptr_q     <= 2'd0;
            hold_q    <= 8'd0;
            grant_q   <= 4'b0000;
            id_q      <= 2'd0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            grant_q   <= grant_d;
            id_q      <= id_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.grant    = grant_q;
    assign bus.grant_id = id_q;
    assign bus.busy     = busy_q;
    assign bus.timeout  = timeout_q;

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Self-checking bench for rr_lock_arbiter, built with HOLD_MAX=4 so that hold-limit timeouts happen often.
// A behavioural model tracks the current owner, how long it has held the grant, and the rotation pointer.
// A compare process checks the DUT against that model on every falling edge.
// Directed sequences check fixed, hand-computed grant patterns.
module tb_rr_lock_arbiter;

    localparam int HOLD = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic chk_en = 1'b0;
    int   tests = 0;
    int   errors = 0;

    rr_lock_arbiter_if bus ();

    rr_lock_arbiter #(.HOLD_MAX(HOLD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: who owns the resource, for how many cycles, and where the next search starts.
    bit m_busy    = 1'b0;
    bit m_timeout = 1'b0;
    int m_id      = 0;
    int m_ptr     = 0;
    int m_held    = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_busy = 0; m_timeout = 0; m_id = 0; m_ptr = 0; m_held = 0;
        end else begin
            m_timeout = 0;
            if (!m_busy) begin
                if (bus.req != 4'b0000) begin
                    for (int k = 3; k >= 0; k--) begin
                        if (bus.req[(m_ptr + k) % 4]) m_id = (m_ptr + k) % 4;
                    end
                    m_busy = 1;
                    m_held = 1;
                end
            end else if (!bus.done && bus.req[m_id] && m_held < HOLD) begin
                m_held++;
            end else begin
                m_timeout = !bus.done && bus.req[m_id];
                m_busy    = 0;
                m_ptr     = (m_id + 1) % 4;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare the DUT against the model on every falling edge, once a reset has been applied.
    always @(negedge clk) begin
        if (chk_en) begin
            check("model grant", 32'(bus.grant), m_busy ? 32'(1 << m_id) : 32'd0);
            check("model busy", 32'(bus.busy), 32'(m_busy));
            check("model timeout", 32'(bus.timeout), 32'(m_timeout));
            if (m_busy) check("model grant_id", 32'(bus.grant_id), 32'(m_id));
        end
    end

    // Apply one reset edge, check the reset outputs, and return at the falling edge where cycle 0 begins.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; bus.req = 4'b0000; bus.done = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        check("reset grant", 32'(bus.grant), 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset timeout", 32'(bus.timeout), 32'd0);
        reset = 1'b0;
    endtask

    logic [3:0] exp_seq [13] = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000,
                                 4'b0100, 4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000,
                                 4'b0001};
    logic [3:0] exp_hold [6] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0001};
    logic       exp_to [6]   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        int run;
        bus.req = 4'b0000; bus.done = 1'b0;

        // All four requesters active, with done on each grant's second cycle: strict rotation.
        do_reset();
        bus.req = 4'b1111; run = 0;
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            check($sformatf("rotate c%0d", c), 32'(bus.grant), 32'(exp_seq[c-1]));
            run = (bus.grant != 4'b0000) ? run + 1 : 0;
            bus.done = (run == 2);
        end
        bus.done = 1'b0;

        // Single requester 2; done in cycle 3; the next search starts from requester 3.
        do_reset();
        bus.req = 4'b0100;
        @(negedge clk);
        check("r2 grant", 32'(bus.grant), 32'h4);
        check("r2 grant_id", 32'(bus.grant_id), 32'd2);
        check("r2 busy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        @(negedge clk);
        bus.done = 1'b1; bus.req = 4'b1111;
        @(negedge clk);
        bus.done = 1'b0;
        check("r2 released", 32'(bus.grant), 32'h0);
        @(negedge clk);
        check("r2 next from ptr3", 32'(bus.grant), 32'h8);

        // Hold limit of 4 cycles: timeout pulse, then a regrant to the same requester.
        do_reset();
        bus.req = 4'b0001;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            check($sformatf("hold grant c%0d", c), 32'(bus.grant), 32'(exp_hold[c-1]));
            check($sformatf("hold timeout c%0d", c), 32'(bus.timeout), 32'(exp_to[c-1]));
        end

        // done arrives in the same cycle the limit is reached: a normal release with no timeout.
        do_reset();
        bus.req = 4'b0001;
        for (int c = 1; c <= 4; c++) @(negedge clk);
        check("limit+done grant c4", 32'(bus.grant), 32'h1);
        bus.done = 1'b1;
        @(negedge clk);
        bus.done = 1'b0;
        check("limit+done grant c5", 32'(bus.grant), 32'h0);
        check("limit+done timeout c5", 32'(bus.timeout), 32'd0);

        // The owner drops its request mid-grant: release, no timeout, and the pointer moves to 2.
        do_reset();
        bus.req = 4'b0010;
        @(negedge clk);
        @(negedge clk);
        bus.req = 4'b0000;
        @(negedge clk);
        check("drop grant", 32'(bus.grant), 32'h0);
        check("drop timeout", 32'(bus.timeout), 32'd0);
        bus.req = 4'b1111;
        @(negedge clk);
        check("drop next ptr2", 32'(bus.grant), 32'h4);

        // Reset during requester 3's second grant cycle; afterwards the search starts at 0 again.
        do_reset();
        bus.req = 4'b1000;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid reset grant", 32'(bus.grant), 32'h0);
        check("mid reset busy", 32'(bus.busy), 32'd0);
        check("mid reset timeout", 32'(bus.timeout), 32'd0);
        reset = 1'b0; bus.req = 4'b1001;
        @(negedge clk);
        check("post reset ptr0", 32'(bus.grant), 32'h1);

        // Random traffic against the model. Requests are mostly stable so that the hold limit is reached.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 3) == 0) bus.req = 4'($urandom_range(0, 15));
            bus.done = ($urandom_range(0, 5) == 0);
        end
        @(negedge clk);
        reset = 1'b0; bus.req = 4'b0000; bus.done = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/rr_lock_arbiter.md
RR_LOCK_ARBITER -- requirements
Module: rr_lock_arbiter

Interface
REQ-001 The block SHALL have parameter HOLD_MAX, default 16, the maximum number of consecutive cycles one grant is held; legal range 2..255.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  reset SHALL be synchronous and active-high.
REQ-004 req  input  4  request vector, bit i = requester i; level-sensitive.
REQ-005 done  input  1  shared resource signals the current transaction has completed.
REQ-006 grant  output  4  registered one-hot grant, or all zero.
REQ-007 grant_id  output  2  registered index of the granted requester; valid only while busy=1.
REQ-008 busy  output  1  registered; high exactly while grant is non-zero.
REQ-009 timeout  output  1  registered one-cycle pulse when a grant is revoked by the HOLD_MAX limit.

Function
REQ-010 The block SHALL implement states IDLE, GRANT and RELEASE.
REQ-011 The block SHALL keep a 2-bit priority pointer ptr; requester ptr has highest priority, then ptr+1, ptr+2, ptr+3 (mod 4).
REQ-012 In IDLE or RELEASE with req non-zero, the block SHALL select the first set bit of req searching from ptr upward with wrap-around, and enter GRANT.
REQ-013 In IDLE or RELEASE with req non-zero, grant SHALL assert on the next cycle.
REQ-014 In IDLE or RELEASE with req=0, the next state SHALL be IDLE and grant SHALL stay 0.
REQ-015 Grant latency SHALL be one cycle: req sampled at edge t gives grant valid after edge t+1.
REQ-016 On entering GRANT, an 8-bit hold counter SHALL load 1, then increment once per cycle spent in GRANT.
REQ-017 In GRANT the block SHALL release when done=1, when req[grant_id]=0, or when the hold counter equals HOLD_MAX.
REQ-018 A GRANT release SHALL make grant 0 on the next cycle, enter RELEASE and set ptr=grant_id+1 (mod 4, 3 wraps to 0).
REQ-019 The block SHALL hold a grant for at most HOLD_MAX cycles.
REQ-020 timeout SHALL pulse high for one cycle, coincident with the first grant=0 cycle, only when release was caused solely by the hold limit.
REQ-021 If done=1 or req[grant_id]=0 in the same cycle the limit is reached, the release SHALL be normal with timeout=0.
REQ-022 Changes on non-granted req bits during GRANT SHALL be ignored.
REQ-023 done SHALL be ignored in IDLE and RELEASE.
REQ-024 RELEASE SHALL last exactly one cycle with grant=0.
REQ-025 Consecutive grants SHALL be separated by exactly one idle cycle, including back-to-back grants to the same requester.
REQ-026 A grant SHALL always be one-hot, and grant_id SHALL encode the set bit.
REQ-027 A continuously requesting requester SHALL be granted within 4 arbitration rounds.

Reset
REQ-028 While reset=1 at a clock edge: state=IDLE, ptr=0, hold counter=0, grant=4'b0000, grant_id=0, busy=0, timeout=0.
REQ-029 Reset SHALL override all other inputs, including mid-GRANT; grant SHALL be 0 in the cycle after reset is sampled.
REQ-030 No timeout pulse SHALL be generated by reset.
REQ-031 After reset deasserts, the first arbitration SHALL use ptr=0.

Verification
REQ-032 Reset, then req=4'b1111 held, done pulsed on 2nd grant cycle each time -> grant sequence 0001,0010,0100,1000,0001, each separated by one zero cycle.
REQ-033 Reset, req=4'b0100 at cycle 0 -> grant=0100, grant_id=2, busy=1 from cycle 1; done at cycle 3 -> grant=0 at cycle 4; next grant after RELEASE searches from 3.
REQ-034 HOLD_MAX=4, req=4'b0001 held, done=0 -> grant high cycles 1-4, grant=0 with timeout=1 at cycle 5, regrant 0001 at cycle 6.
REQ-035 HOLD_MAX=4, done=1 on 4th grant cycle -> release with timeout=0.
REQ-036 Granted requester drops req mid-grant with done=0 -> grant=0 next cycle; ptr advances; timeout=0.
REQ-037 reset=1 asserted during 2nd grant cycle to requester 3 with req=4'b1000 held -> outputs 0 next cycle; after reset release, req=4'b1001 -> requester 0 granted first.
